mult_host_ctrl: RTL and testbench

//   Host-side initiator for the processor412 multiply engine. Accepts a 32x32

---
 rtl/mult_host_ctrl_if.sv | 38 +++
 rtl/mult_host_ctrl.sv | 159 +++++++++++++++
 tb/tb_mult_host_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_host_ctrl_if.sv
// Bundles the client request/response handshake and the processor412
// start/ready and data-memory port of the multiply host controller.
interface mult_host_ctrl_if #(
    parameter int unsigned AW = 9,
    parameter int unsigned DW = 32
) ();
    // Client side
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] req_a;
    logic [DW-1:0] req_b;
    logic          rsp_valid;
    logic [2*DW-1:0] rsp_prod;
    logic          rsp_err;
    logic          busy;
    // Processor side
    logic          start;
    logic          ready;
    logic          dcen;
    logic          dwen;
    logic [AW-1:0] dadr;
    logic [DW-1:0] dinp;
    logic [DW-1:0] dout;

    // The controller itself
    modport master (
        input  req_valid, req_a, req_b, ready, dout,
        output req_ready, rsp_valid, rsp_prod, rsp_err, busy,
        output start, dcen, dwen, dadr, dinp
    );

    // Client plus processor seen as one environment
    modport slave (
        output req_valid, req_a, req_b, ready, dout,
        input  req_ready, rsp_valid, rsp_prod, rsp_err, busy,
        input  start, dcen, dwen, dadr, dinp
    );
endinterface

// File: rtl/mult_host_ctrl.sv
// Host-side initiator for the processor412 multiply engine: writes two
// operands into processor dmem, pulses start, waits for a fresh rising edge
// on ready (bounded by TIMEOUT), then reads back the 64-bit product.
module mult_host_ctrl #(
    parameter int unsigned AW      = 9,
    parameter int unsigned DW      = 32,
    parameter int unsigned OPA_ADR = 0,
    parameter int unsigned OPB_ADR = 1,
    parameter int unsigned RHI_ADR = 2,
    parameter int unsigned RLO_ADR = 3,
    parameter int unsigned TIMEOUT = 1024
) (
    input logic              ck,
    input logic              rb,
    mult_host_ctrl_if.master bus
);
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [3:0] {
        StIdle, StWrA, StWrB, StStart, StWait, StRdHi, StRdLo, StRdCap, StDone, StErr
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   opa_q, opa_d;
    logic [DW-1:0]   opb_q, opb_d;
    logic [DW-1:0]   hi_q, hi_d;
    logic [2*DW-1:0] prod_q, prod_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            ready_q;
    logic            rise;
    logic            start_q, start_d;
    logic            dcen_q, dcen_d;
    logic            dwen_q, dwen_d;
    logic [AW-1:0]   dadr_q, dadr_d;
    logic [DW-1:0]   dinp_q, dinp_d;

    // Only a fresh low-to-high transition counts as completion.
    assign rise = bus.ready & ~ready_q;

    // Next state, datapath captures, and processor-side outputs decoded from the next state
    // so that every processor-facing signal comes straight from a flop.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        prod_d  = prod_q;
        timer_d = timer_q;
        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    opa_d   = bus.req_a;
                    opb_d   = bus.req_b;
                    state_d = StWrA;
                end
            end
            StWrA:   state_d = StWrB;
            StWrB:   state_d = StStart;
            StStart: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                if (rise) begin
                    state_d = StRdHi;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    prod_d  = '0;
                    state_d = StErr;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StRdHi:  state_d = StRdLo;
            StRdLo: begin
                hi_d    = bus.dout;
                state_d = StRdCap;
            end
            StRdCap: begin
                prod_d  = {hi_q, bus.dout};
                state_d = StDone;
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        start_d = 1'b0;
        dcen_d  = 1'b0;
        dwen_d  = 1'b0;
        dadr_d  = '0;
        dinp_d  = '0;
        case (state_d)
            StWrA: begin
                dcen_d = 1'b1;
                dwen_d = 1'b1;
                dadr_d = AW'(OPA_ADR);
                dinp_d = opa_d;
            end
            StWrB: begin
                dcen_d = 1'b1;
                dwen_d = 1'b1;
                dadr_d = AW'(OPB_ADR);
                dinp_d = opb_d;
            end
            StStart: start_d = 1'b1;
            StRdHi: begin
                dcen_d = 1'b1;
                dadr_d = AW'(RHI_ADR);
            end
            StRdLo: begin
                dcen_d = 1'b1;
                dadr_d = AW'(RLO_ADR);
            end
            default: ;
        endcase
    end

    // State, datapath and registered processor-side outputs; reset aborts any operation.
    always_ff @(posedge ck or negedge rb) begin
        if (!rb) begin
            state_q <= StIdle;
            opa_q   <= '0;
            opb_q   <= '0;
            hi_q    <= '0;
            prod_q  <= '0;
            timer_q <= '0;
            ready_q <= 1'b0;
            start_q <= 1'b0;
            dcen_q  <= 1'b0;
            dwen_q  <= 1'b0;
            dadr_q  <= '0;
            dinp_q  <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            prod_q  <= prod_d;
            timer_q <= timer_d;
            ready_q <= bus.ready;
            start_q <= start_d;
            dcen_q  <= dcen_d;
            dwen_q  <= dwen_d;
            dadr_q  <= dadr_d;
            dinp_q  <= dinp_d;
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.rsp_valid = (state_q == StDone) || (state_q == StErr);
    assign bus.rsp_err   = (state_q == StErr);
    assign bus.rsp_prod  = prod_q;
    assign bus.start     = start_q;
    assign bus.dcen      = dcen_q;
    assign bus.dwen      = dwen_q;
    assign bus.dadr      = dadr_q;
    assign bus.dinp      = dinp_q;
endmodule

// File: tb/tb_mult_host_ctrl.sv
// Bench for mult_host_ctrl: behavioural processor412 model on the dmem/start/ready
// port, scoreboard of expected responses, one task per scenario.
module tb_mult_host_ctrl;
    localparam int unsigned AW  = 9;
    localparam int unsigned DW  = 32;
    localparam int unsigned TO  = 32;
    localparam int          LAT = 6;

    logic ck = 1'b0;
    logic rb;
    always #5 ck = ~ck;

    mult_host_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    mult_host_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .ck  (ck),
        .rb  (rb),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp_prod_q[$];
    bit          exp_err_q[$];

    // Processor model state
    logic [DW-1:0] dmem [0:(1<<AW)-1];
    int wr_a_cnt = 0, wr_b_cnt = 0, wr_other_cnt = 0, start_cnt = 0;
    int lat = 0;
    bit stuck = 1'b0;

    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b);
        return 64'(a) * 64'(b);
    endfunction

    // Behavioural processor412: dmem with 1-cycle read latency, start -> ready after LAT
    always @(posedge ck) begin
        if (!rb) begin
            bus.ready <= 1'b0;
            bus.dout  <= '0;
            lat       <= 0;
        end else begin
            if (bus.dcen && bus.dwen) begin
                dmem[bus.dadr] <= bus.dinp;
                if (bus.dadr == 0)      wr_a_cnt     <= wr_a_cnt + 1;
                else if (bus.dadr == 1) wr_b_cnt     <= wr_b_cnt + 1;
                else                    wr_other_cnt <= wr_other_cnt + 1;
            end
            if (bus.dcen && !bus.dwen) bus.dout <= dmem[bus.dadr];
            if (stuck) begin
                bus.ready <= 1'b1;
                lat       <= 0;
                if (bus.start) start_cnt <= start_cnt + 1;
            end else if (bus.start) begin
                start_cnt <= start_cnt + 1;
                bus.ready <= 1'b0;
                lat       <= LAT;
            end else if (lat > 0) begin
                lat <= lat - 1;
                if (lat == 1) begin
                    dmem[2]   <= 32'(mul64(dmem[0], dmem[1]) >> 32);
                    dmem[3]   <= 32'(mul64(dmem[0], dmem[1]));
                    bus.ready <= 1'b1;
                end
            end
        end
    end

    // Response scoreboard: pop on every rsp_valid
    initial begin
        forever begin
            @(negedge ck);
            if (rb && bus.rsp_valid) begin
                n_tests++;
                if (exp_prod_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected: got rsp_valid prod=%h err=%0b, required none",
                             bus.rsp_prod, bus.rsp_err);
                end else begin
                    if (bus.rsp_prod !== exp_prod_q[0]) begin
                        n_fail++;
                        $display("FAIL rsp_prod: got %h, required %h", bus.rsp_prod, exp_prod_q[0]);
                    end
                    n_tests++;
                    if (bus.rsp_err !== exp_err_q[0]) begin
                        n_fail++;
                        $display("FAIL rsp_err: got %0b, required %0b", bus.rsp_err, exp_err_q[0]);
                    end
                    void'(exp_prod_q.pop_front());
                    void'(exp_err_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    // Presents a request at a negedge once req_ready is seen; returns at that negedge.
    task automatic drive_req(input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] ep, input bit ee, input bit push);
        int k = 0;
        @(negedge ck);
        while (!bus.req_ready && k < 200) begin
            @(negedge ck);
            k++;
        end
        n_tests++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ready_wait: got %0b, required 1", bus.req_ready);
        end
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_valid = 1'b1;
        if (push) begin
            exp_prod_q.push_back(ep);
            exp_err_q.push_back(ee);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin
            @(negedge ck);
            k++;
        end while ((exp_prod_q.size() != 0 || bus.busy) && k < 200);
        n_tests++;
        if (bus.busy || exp_prod_q.size() != 0) begin
            n_fail++;
            $display("FAIL wait_idle: busy=%0b pending=%0d, required 0/0",
                     bus.busy, exp_prod_q.size());
        end
    endtask

    task automatic wait_start();
        int k = 0;
        while (!bus.start && k < 50) begin
            @(negedge ck);
            k++;
        end
        n_tests++;
        if (bus.start !== 1'b1) begin
            n_fail++;
            $display("FAIL start_seen: got %0b, required 1", bus.start);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] ep, input bit ee);
        drive_req(a, b, ep, ee, 1'b1);
        @(negedge ck);
        bus.req_valid = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset();
        rb = 1'b0;
        repeat (2) @(negedge ck);
        #1;
        n_tests++;
        if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs: req_ready=%0b busy=%0b, required 1/0", bus.req_ready, bus.busy);
        end
        n_tests++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_prod !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rsp: valid=%0b err=%0b prod=%h, required 0/0/0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_prod);
        end
        n_tests++;
        if ({bus.start, bus.dcen, bus.dwen, bus.dadr, bus.dinp} !== '0) begin
            n_fail++;
            $display("FAIL reset_proc: start=%0b dcen=%0b dwen=%0b dadr=%h dinp=%h, required 0",
                     bus.start, bus.dcen, bus.dwen, bus.dadr, bus.dinp);
        end
        @(negedge ck);
        rb = 1'b1;
        repeat (2) @(negedge ck);
    endtask

    task automatic test_basic();
        int s0 = start_cnt;
        int a0 = wr_a_cnt;
        send(32'h12345678, 32'hFEDCBA98, 64'h121FA00A_35068740, 1'b0);
        n_tests++;
        if (dmem[0] !== 32'h12345678 || dmem[1] !== 32'hFEDCBA98) begin
            n_fail++;
            $display("FAIL basic_dmem: got %h/%h, required 12345678/fedcba98", dmem[0], dmem[1]);
        end
        n_tests++;
        if (start_cnt - s0 != 1 || wr_a_cnt - a0 != 1) begin
            n_fail++;
            $display("FAIL basic_counts: starts=%0d writesA=%0d, required 1/1",
                     start_cnt - s0, wr_a_cnt - a0);
        end
    endtask

    task automatic test_corner();
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0);
        send(32'h0, 32'hDEADBEEF, 64'h0, 1'b0);
    endtask

    task automatic test_timeout();
        int s_at = -1;
        int r_at = -1;
        stuck = 1'b1;
        repeat (3) @(negedge ck);
        drive_req(32'h55, 32'h66, 64'h0, 1'b1, 1'b1);
        for (int k = 1; k <= 50; k++) begin
            @(negedge ck);
            if (k == 1) bus.req_valid = 1'b0;
            if (bus.start && s_at < 0) s_at = k;
            if (bus.rsp_valid && r_at < 0) r_at = k;
        end
        n_tests++;
        if (s_at != 3 || r_at != 4 + TO) begin
            n_fail++;
            $display("FAIL timeout_timing: start at %0d rsp at %0d, required 3 and %0d",
                     s_at, r_at, 4 + TO);
        end
        stuck = 1'b0;
        wait_idle();
    endtask

    task automatic test_ignore_busy();
        int s0 = start_cnt;
        int a0 = wr_a_cnt;
        int b0 = wr_b_cnt;
        drive_req(32'h1000, 32'h2000, mul64(32'h1000, 32'h2000), 1'b0, 1'b1);
        @(negedge ck);
        bus.req_valid = 1'b0;
        wait_start();
        repeat (2) @(negedge ck);
        bus.req_a     = 32'hAAAA;
        bus.req_b     = 32'hBBBB;
        bus.req_valid = 1'b1;
        n_tests++;
        if (bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_req_ready: got %0b, required 0", bus.req_ready);
        end
        @(negedge ck);
        bus.req_valid = 1'b0;
        wait_idle();
        send(32'd3, 32'd5, 64'd15, 1'b0);
        n_tests++;
        if (start_cnt - s0 != 2 || wr_a_cnt - a0 != 2 || wr_b_cnt - b0 != 2 || wr_other_cnt != 0)
        begin
            n_fail++;
            $display("FAIL ignore_counts: starts=%0d wrA=%0d wrB=%0d other=%0d, required 2/2/2/0",
                     start_cnt - s0, wr_a_cnt - a0, wr_b_cnt - b0, wr_other_cnt);
        end
        n_tests++;
        if (dmem[0] !== 32'd3 || dmem[1] !== 32'd5) begin
            n_fail++;
            $display("FAIL ignore_dmem: got %h/%h, required 3/5", dmem[0], dmem[1]);
        end
    endtask

    task automatic test_reset_midop();
        drive_req(32'h11, 32'h22, 64'h0, 1'b0, 1'b0);
        @(negedge ck);
        bus.req_valid = 1'b0;
        wait_start();
        repeat (2) @(negedge ck);
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_busy: got %0b, required 1", bus.busy);
        end
        rb = 1'b0;
        #1;
        n_tests++;
        if ({bus.start, bus.dcen, bus.dwen, bus.busy, bus.rsp_valid} !== 5'b0 ||
            bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_reset: start=%0b dcen=%0b dwen=%0b busy=%0b req_ready=%0b, required 0/0/0/0/1",
                     bus.start, bus.dcen, bus.dwen, bus.busy, bus.req_ready);
        end
        repeat (2) @(negedge ck);
        rb = 1'b1;
        repeat (2) @(negedge ck);
        send(32'd7, 32'd9, 64'd63, 1'b0);
    endtask

    task automatic test_cycle_timing();
        logic [AW-1:0] dadr_log [64];
        logic          dcen_log [64];
        int s_at = -1, s_n = 0, tr = -1, r_at = -1;
        logic prev_rdy;
        drive_req(32'hA5A5, 32'h5A5A, mul64(32'hA5A5, 32'h5A5A), 1'b0, 1'b1);
        prev_rdy = bus.ready;
        for (int k = 1; k < 40; k++) begin
            @(negedge ck);
            if (k == 1) bus.req_valid = 1'b0;
            dadr_log[k] = bus.dadr;
            dcen_log[k] = bus.dcen;
            if (bus.start) begin
                s_n++;
                if (s_at < 0) s_at = k;
            end
            if (bus.ready && !prev_rdy && tr < 0 && s_at > 0) tr = k;
            if (bus.rsp_valid && r_at < 0) r_at = k;
            prev_rdy = bus.ready;
        end
        n_tests++;
        if (s_at != 3 || s_n != 1) begin
            n_fail++;
            $display("FAIL start_timing: first at %0d count %0d, required 3 and 1", s_at, s_n);
        end
        n_tests++;
        if (tr < 4 || tr > 30) begin
            n_fail++;
            $display("FAIL ready_rise: seen at %0d, required within 4..30", tr);
        end else begin
            n_tests++;
            if (dadr_log[tr+1] !== 9'd2 || dcen_log[tr+1] !== 1'b1 ||
                dadr_log[tr+2] !== 9'd3 || dcen_log[tr+2] !== 1'b1) begin
                n_fail++;
                $display("FAIL read_addr: tr+1 dadr=%0d dcen=%0b tr+2 dadr=%0d dcen=%0b, required 2/1 3/1",
                         dadr_log[tr+1], dcen_log[tr+1], dadr_log[tr+2], dcen_log[tr+2]);
            end
            n_tests++;
            if (r_at != tr + 4) begin
                n_fail++;
                $display("FAIL rsp_latency: rsp at %0d, required %0d", r_at, tr + 4);
            end
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int k = 0;
        drive_req(32'h100, 32'h200, mul64(32'h100, 32'h200), 1'b0, 1'b1);
        @(negedge ck);
        bus.req_valid = 1'b0;
        while (!bus.rsp_valid && k < 100) begin
            @(negedge ck);
            k++;
        end
        @(negedge ck);
        n_tests++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready: got %0b, required 1", bus.req_ready);
        end
        bus.req_a     = 32'h300;
        bus.req_b     = 32'h400;
        bus.req_valid = 1'b1;
        exp_prod_q.push_back(mul64(32'h300, 32'h400));
        exp_err_q.push_back(1'b0);
        @(negedge ck);
        bus.req_valid = 1'b0;
        n_tests++;
        if (bus.busy !== 1'b1 || bus.dcen !== 1'b1 || bus.dinp !== 32'h300) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%0b dcen=%0b dinp=%h, required 1/1/300",
                     bus.busy, bus.dcen, bus.dinp);
        end
        wait_idle();
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        rb            = 1'b0;
        test_reset();
        test_basic();
        test_corner();
        test_timeout();
        test_ignore_busy();
        test_reset_midop();
        test_cycle_timing();
        test_back_to_back();
        n_tests++;
        if (exp_prod_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d pending, required 0", exp_prod_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
